// File: rtl/jrb8_spi_pkg.sv
// Shared constants, state/operation types and frame helpers for the jrb8 SPI
// memory responder.
package jrb8_spi_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam int         ROM_RD_BITS   = 40;
   localparam int         RAM_BITS      = 32;
   localparam int         FRAME_W       = ROM_RD_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } spi_state_e;

   typedef enum logic [1:0] {
      OP_NOP    = 2'd0,
      OP_ROM_RD = 2'd1,
      OP_RAM_RD = 2'd2,
      OP_RAM_WR = 2'd3
   } spi_op_e;

   // Write wins over RAM read, which wins over ROM fetch.
   function automatic spi_op_e decode_op(input logic rd_rom, input logic rd_ram,
                                         input logic wr_ram);
      if (wr_ram)      return OP_RAM_WR;
      else if (rd_ram) return OP_RAM_RD;
      else if (rd_rom) return OP_ROM_RD;
      else             return OP_NOP;
   endfunction

   // Frames are left-aligned so the first bit on the wire is always bit FRAME_W-1;
   // read-data slots are zero so mosi idles low while the byte comes back.
   function automatic logic [FRAME_W-1:0] build_frame(input spi_op_e op,
                                                      input logic [15:0] addr,
                                                      input logic [7:0] wdata);
      logic [FRAME_W-1:0] f;
      f = '0;
      case (op)
         OP_ROM_RD: f = {SPI_CMD_READ, 8'h00, addr, 8'h00};
         OP_RAM_RD: f = {SPI_CMD_READ, addr, 8'h00, 8'h00};
         OP_RAM_WR: f = {SPI_CMD_WRITE, addr, wdata, 8'h00};
         default:   f = '0;
      endcase
      return f;
   endfunction

   function automatic logic [5:0] frame_len(input spi_op_e op);
      return (op == OP_ROM_RD) ? 6'(ROM_RD_BITS) : 6'(RAM_BITS);
   endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: prescaler, sclk phase, MSB-first transmit register,
// receive register and bit counter for one frame per load.
module spi_shifter
   import jrb8_spi_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [FRAME_W-1:0] frame_i,
   input  logic [5:0]         len_i,
   input  logic               miso_i,
   output logic               sclk_o,
   output logic               mosi_o,
   output logic               last_bit_o,
   output logic [7:0]         rx_byte_o
);

   localparam int             DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);

   logic [DW-1:0]      div_q, div_d;
   logic               phase_q, phase_d;
   logic               active_q, active_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [7:0]         rx_q, rx_d;
   logic [5:0]         bit_q, bit_d;
   logic               tick;

   assign tick = active_q && (div_q == DIV_MAX);

   always_comb begin
      div_d    = div_q;
      phase_d  = phase_q;
      active_d = active_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      bit_d    = bit_q;
      if (load_i) begin
         div_d    = '0;
         phase_d  = 1'b0;
         active_d = 1'b1;
         tx_d     = frame_i;
         bit_d    = len_i - 6'd1;
      end else if (active_q) begin
         if (tick) begin
            div_d = '0;
            if (!phase_q) begin
               // End of the low phase: sclk rises here and miso is captured.
               phase_d = 1'b1;
               rx_d    = {rx_q[6:0], miso_i};
            end else begin
               // End of the high phase: the next bit appears while sclk is low.
               phase_d = 1'b0;
               if (bit_q == 6'd0) begin
                  active_d = 1'b0;
               end else begin
                  bit_d = bit_q - 6'd1;
                  tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
               end
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         phase_q  <= 1'b0;
         active_q <= 1'b0;
         tx_q     <= '0;
         rx_q     <= '0;
         bit_q    <= '0;
      end else begin
         div_q    <= div_d;
         phase_q  <= phase_d;
         active_q <= active_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         bit_q    <= bit_d;
      end
   end

   assign sclk_o     = phase_q;
   assign mosi_o     = active_q & tx_q[FRAME_W-1];
   assign last_bit_o = tick && phase_q && (bit_q == 6'd0);
   assign rx_byte_o  = rx_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// jrb8 SPI memory responder: accepts a byte transfer request from the control
// unit, runs the flash/SRAM frame and returns the read byte on rdata.
module spi_mem_ctrl
   import jrb8_spi_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_executing,
   output logic        spi_done,
   input  logic        rd_rom,
   input  logic        rd_ram,
   input  logic        wr_ram,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        cs_rom_n,
   output logic        cs_ram_n,
   output spi_state_e  dbg_state_o
);

   spi_state_e state_q, state_d;
   spi_op_e    op_q, op_d;
   spi_op_e    req_op;
   logic [7:0] rdata_q, rdata_d;
   logic       load;
   logic       last_bit;
   logic [7:0] rx_byte;

   assign req_op = decode_op(rd_rom, rd_ram, wr_ram);
   assign load   = (state_q == IDLE) && spi_executing && (req_op != OP_NOP);

   spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .frame_i    (build_frame(req_op, addr, wdata)),
      .len_i      (frame_len(req_op)),
      .miso_i     (miso),
      .sclk_o     (sclk),
      .mosi_o     (mosi),
      .last_bit_o (last_bit),
      .rx_byte_o  (rx_byte)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (spi_executing) begin
               op_d    = req_op;
               state_d = (req_op == OP_NOP) ? FINISH : SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
            if (op_q == OP_ROM_RD || op_q == OP_RAM_RD) rdata_d = rx_byte;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rdata_q <= rdata_d;
      end
   end

   // Decoded from registered state only, so spi_done cannot glitch mid-frame.
   assign spi_done    = (state_q == IDLE);
   assign cs_rom_n    = !((state_q == SHIFT) && (op_q == OP_ROM_RD));
   assign cs_ram_n    = !((state_q == SHIFT) && (op_q == OP_RAM_RD || op_q == OP_RAM_WR));
   assign rdata       = rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: two instances (CLK_DIV 1 and 2) driven with directed
// and random transfers, checked against a byte-level frame/timing model.
module tb_spi_mem_ctrl;
   import jrb8_spi_pkg::*;

   localparam int NU = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s[NU], exec_s[NU], rd_rom_s[NU], rd_ram_s[NU], wr_ram_s[NU], miso_s[NU];
   logic [15:0] addr_s[NU];
   logic [7:0]  wdata_s[NU], rdata_s[NU];
   logic        done_s[NU], sclk_s[NU], mosi_s[NU], csrom_s[NU], csram_s[NU];
   spi_state_e  dbg_s[NU];
   logic [7:0]  rdata_m[NU];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NU; g++) begin : g_dut
      spi_mem_ctrl #(.CLK_DIV(g + 1)) u_dut (
         .clk           (clk),
         .rst           (rst_s[g]),
         .spi_executing (exec_s[g]),
         .spi_done      (done_s[g]),
         .rd_rom        (rd_rom_s[g]),
         .rd_ram        (rd_ram_s[g]),
         .wr_ram        (wr_ram_s[g]),
         .addr          (addr_s[g]),
         .wdata         (wdata_s[g]),
         .rdata         (rdata_s[g]),
         .sclk          (sclk_s[g]),
         .mosi          (mosi_s[g]),
         .miso          (miso_s[g]),
         .cs_rom_n      (csrom_s[g]),
         .cs_ram_n      (csram_s[g]),
         .dbg_state_o   (dbg_s[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory-side data: the returned byte in the last 8 bit slots, filler before.
   function automatic logic miso_bit(input int i, input int n, input logic [7:0] mb);
      if (i >= n - 8 && i < n) return mb[7 - (i - (n - 8))];
      return (i % 3) == 1;
   endfunction

   task automatic check_idle(input int u, input string tag);
      check({tag, "_done"}, 64'(done_s[u]), 64'd1);
      check({tag, "_csrom"}, 64'(csrom_s[u]), 64'd1);
      check({tag, "_csram"}, 64'(csram_s[u]), 64'd1);
      check({tag, "_sclk"}, 64'(sclk_s[u]), 64'd0);
      check({tag, "_rdata"}, 64'(rdata_s[u]), 64'(rdata_m[u]));
   endtask

   // Called and returns at a negedge with unit u idle. ops = {wr_ram, rd_ram, rd_rom}.
   task automatic xfer(input int u, input logic [2:0] ops, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] mb, input bit keep,
                       input int abort_at);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      logic [7:0] cur;
      int  div, n, exp_low, low, rom_low, ram_low, rises, viol, fin, budget;
      bit  is_rom, is_ram, is_rd;
      logic prev_sclk, prev_mosi;

      div = u + 1;
      is_rom = 1'b0; is_ram = 1'b0; is_rd = 1'b0; n = 0;
      if (ops[2]) begin
         is_ram = 1'b1; n = 32;
         exp_q = '{8'h02, a[15:8], a[7:0], wd};
      end else if (ops[1]) begin
         is_ram = 1'b1; is_rd = 1'b1; n = 32;
         exp_q = '{8'h03, a[15:8], a[7:0], 8'h00};
      end else if (ops[0]) begin
         is_rom = 1'b1; is_rd = 1'b1; n = 40;
         exp_q = '{8'h03, 8'h00, a[15:8], a[7:0], 8'h00};
      end
      exp_low = (n == 0) ? 1 : 2 * n * div + 1;

      rd_rom_s[u] = ops[0]; rd_ram_s[u] = ops[1]; wr_ram_s[u] = ops[2];
      addr_s[u] = a; wdata_s[u] = wd; exec_s[u] = 1'b1;
      miso_s[u] = miso_bit(0, n, mb);
      low = 0; rom_low = 0; ram_low = 0; rises = 0; viol = 0; fin = 0; cur = '0;
      prev_sclk = 1'b0; prev_mosi = mosi_s[u];

      for (budget = 0; budget < 1000; budget++) begin
         @(posedge clk); @(negedge clk);
         if (budget == 0) check("accept", 64'(done_s[u]), 64'd0);
         if (done_s[u]) break;
         low++;
         if (!csrom_s[u]) rom_low++;
         if (!csram_s[u]) ram_low++;
         if (!csrom_s[u] && !csram_s[u]) viol++;
         if (sclk_s[u] && mosi_s[u] != prev_mosi) viol++;
         if (csrom_s[u] && csram_s[u]) begin
            fin++;
            if (sclk_s[u]) viol++;
         end
         if (sclk_s[u] && !prev_sclk) begin
            cur = {cur[6:0], mosi_s[u]};
            rises++;
            if (rises % 8 == 0) got_q.push_back(cur);
         end
         prev_sclk = sclk_s[u]; prev_mosi = mosi_s[u];
         if (!sclk_s[u]) miso_s[u] = miso_bit(rises, n, mb);
         if (!keep) exec_s[u] = 1'($urandom_range(0, 1));
         if (abort_at > 0 && rises == abort_at && !keep) begin
            rst_s[u] = 1'b1; exec_s[u] = 1'b0;
            @(posedge clk); @(negedge clk);
            rst_s[u] = 1'b0;
            rdata_m[u] = 8'h00;
            check_idle(u, "abort");
            return;
         end
      end
      if (!keep) exec_s[u] = 1'b0;

      check("timeout", 64'(budget < 1000), 64'd1);
      check("done_low", 64'(low), 64'(exp_low));
      check("cs_rom_low", 64'(rom_low), is_rom ? 64'(2 * n * div) : 64'd0);
      check("cs_ram_low", 64'(ram_low), is_ram ? 64'(2 * n * div) : 64'd0);
      check("finish_cycles", 64'(fin), 64'd1);
      check("protocol_viol", 64'(viol), 64'd0);
      check("sclk_rises", 64'(rises), 64'(n));
      check("mosi_nbytes", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check("mosi_byte", 64'(got_q[i]), 64'(exp_q[i]));
      if (is_rd) rdata_m[u] = mb;
      check("rdata", 64'(rdata_s[u]), 64'(rdata_m[u]));
      check("state_idle", 64'(dbg_s[u]), 64'(IDLE));
   endtask

   initial begin
      for (int u = 0; u < NU; u++) begin
         rst_s[u] = 1'b1; exec_s[u] = 1'b0; rd_rom_s[u] = 1'b0; rd_ram_s[u] = 1'b0;
         wr_ram_s[u] = 1'b0; addr_s[u] = '0; wdata_s[u] = '0; miso_s[u] = 1'b0;
         rdata_m[u] = 8'h00;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < NU; u++) rst_s[u] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int u = 0; u < NU; u++) begin
            check_idle(u, "reset");
            check("reset_mosi", 64'(mosi_s[u]), 64'd0);
            check("reset_state", 64'(dbg_s[u]), 64'(IDLE));
         end
         @(posedge clk); @(negedge clk);
      end

      // ROM fetch at CLK_DIV=1, then RAM read and write at CLK_DIV=2.
      xfer(0, 3'b001, 16'h1234, 8'h00, 8'hA5, 1'b0, -1);
      xfer(1, 3'b010, 16'h4321, 8'h00, 8'h77, 1'b0, -1);
      xfer(1, 3'b100, 16'h00FF, 8'h5A, 8'h00, 1'b0, -1);

      // NOP followed by back-to-back RAM read and ROM read with the request held.
      xfer(0, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b1, -1);
      xfer(0, 3'b010, 16'h0ABC, 8'h00, 8'h3C, 1'b1, -1);
      xfer(0, 3'b001, 16'hBEEF, 8'h00, 8'hC3, 1'b0, -1);

      // Priority: all three requested means write.
      xfer(0, 3'b111, 16'h2468, 8'hE1, 8'h55, 1'b0, -1);

      // Reset mid-frame, then a complete frame.
      xfer(0, 3'b001, 16'h5555, 8'h00, 8'h99, 1'b0, 17);
      xfer(0, 3'b001, 16'h1357, 8'h00, 8'h2E, 1'b0, -1);
      xfer(1, 3'b010, 16'hA0A0, 8'h00, 8'h66, 1'b0, 9);
      xfer(1, 3'b010, 16'hA0A1, 8'h00, 8'h81, 1'b0, -1);

      for (int u = 0; u < NU; u++) begin
         for (int k = 0; k < 20; k++) begin
            bit keep;
            int ab;
            keep = (k != 19) && ($urandom_range(0, 3) == 0);
            ab = (!keep && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : -1;
            xfer(u, 3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom),
                 8'($urandom), keep, ab);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI memory responder for the jrb8 computer: it executes the byte transfers that the control unit requests over the `spi_executing`/`spi_done` handshake. Supported transfers are instruction/operand fetches from the external SPI flash ROM, and byte reads and writes on the external SPI SRAM. It sits between the control unit and the chip pins: it latches the address and operation at request time, shifts the SPI frame, and returns the read byte on `rdata`.

## Interface
- `CLK_DIV`, default 1: system clocks per SCLK half-period; legal range ≥1.
- `clk` input 1: system clock, all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `spi_executing` input 1: transfer request level from the control unit.
- `spi_done` output 1: high when idle; low while a transfer is in progress.
- `rd_rom` input 1: request a ROM byte read.
- `rd_ram` input 1: request a RAM byte read.
- `wr_ram` input 1: request a RAM byte write.
- `addr` input 16: byte address (PC or RAM pointer).
- `wdata` input 8: byte to write.
- `rdata` output 8: last byte read.
- `sclk` output 1: SPI clock, mode 0.
- `mosi` output 1: serial data out, MSB first.
- `miso` input 1: serial data in.
- `cs_rom_n` output 1: flash chip select, active-low.
- `cs_ram_n` output 1: SRAM chip select, active-low.

## Operation
- Reset values: `spi_done`=1, `rdata`=0x00, `sclk`=0, `mosi`=0, `cs_rom_n`=1, `cs_ram_n`=1, state IDLE.
- Acceptance: a request is accepted on a cycle where the state is IDLE and `spi_executing`=1. On acceptance, latch `addr`, `wdata` and the operation.
- Operation priority: `wr_ram` > `rd_ram` > `rd_rom`.
- No operation selected: NOP. `spi_done` goes low for exactly 1 cycle, no chip select is asserted, and `rdata` is unchanged.
- State machine:
  - IDLE → SHIFT on acceptance of a real operation.
  - IDLE → FINISH on acceptance of a NOP.
  - SHIFT → FINISH after the last bit's high phase.
  - FINISH → IDLE unconditionally.
- Frames, all MSB first:
  - ROM read: 0x03, then 0x00, addr[15:8], addr[7:0], then 8 read bits. N=40.
  - RAM read: 0x03, addr[15:8], addr[7:0], then 8 read bits. N=32.
  - RAM write: 0x02, addr[15:8], addr[7:0], wdata. N=32.
- SPI mode 0:
  - Each bit holds `sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `mosi` changes only while `sclk` is low.
  - `miso` is sampled on the cycle `sclk` rises.
  - During the read-data bits, `mosi`=0.
- Chip select: the selected `cs_*_n` is low for the whole of SHIFT and high in FINISH and IDLE. The two selects are never low together.
- FINISH: `sclk`=0, selects high. For read operations, `rdata` takes the assembled byte on the FINISH→IDLE edge.
- `spi_executing` changes during SHIFT/FINISH are ignored; the request level is examined only in IDLE.
- Reset mid-transfer: on the next edge, return to reset values. The partial frame is abandoned and `rdata` is cleared.

## Timing
- Request accepted at cycle T:
  - T+1: `spi_done`=0, select low, `mosi`=frame bit N-1, `sclk`=0.
  - T+1+2·N·CLK_DIV: FINISH cycle.
  - T+2+2·N·CLK_DIV: `spi_done`=1, with `rdata` valid in the same cycle.
- `spi_done` low duration: 2·N·CLK_DIV+1 cycles. With CLK_DIV=1 that is 81 cycles for a ROM read and 65 for RAM.
- NOP: `spi_done` is low at T+1 only.
- Back-to-back: if `spi_executing`=1 in the first idle cycle (T+2+2N·CLK_DIV), the next transfer is accepted in that same cycle. There is no mandatory gap beyond that IDLE cycle.
- The control unit detects completion as a 0→1 edge of `spi_done`. The block must never hold `spi_done` low forever and never glitch it high mid-frame.

## Structure
- Package `jrb8_spi_pkg` contains:
  - command constants `SPI_CMD_READ`=8'h03 and `SPI_CMD_WRITE`=8'h02;
  - frame lengths `ROM_RD_BITS`=40 and `RAM_BITS`=32;
  - the state enum {IDLE, SHIFT, FINISH}.
- One sub-module, `spi_shifter`. It owns the CLK_DIV prescaler, the `sclk` phase, the 40-bit output shift register, the 8-bit input shift register and the bit counter. It takes load/length inputs and produces a `last_bit` strobe.
- The top level holds the FSM, operation decode, chip-select muxing and `rdata`.

## Test plan
- Reset: assert `rst` for 2 cycles. Expect `spi_done`=1, both selects=1, `sclk`=0 and `rdata`=0x00, held while `spi_executing`=0.
- ROM read: `addr`=0x1234, `rd_rom`=1, flash model returns 0xA5, CLK_DIV=1. Expect:
  - MOSI stream 03 00 12 34;
  - `cs_rom_n` low 80 cycles, `cs_ram_n` stays 1;
  - `spi_done` rises at T+82 with `rdata`=0xA5.
- RAM write: `addr`=0x00FF, `wdata`=0x5A, CLK_DIV=2. Expect MOSI 02 00 FF 5A on `cs_ram_n`, `spi_done` low 129 cycles, and `rdata` unchanged.
- NOP, then back-to-back: first a request with no operation selected. Expect a single-cycle `spi_done` low pulse and no select activity. Then keep `spi_executing` high and issue a RAM read returning 0x3C followed by a ROM read returning 0xC3. Expect a new acceptance in the first IDLE cycle after each completion and `rdata` sequence 0x3C, then 0xC3.
- Reset mid-frame: assert `rst` for one cycle at bit 17 of a ROM read. On the next edge expect the select high, `spi_done`=1 and `rdata`=0x00. A following request must run a complete, correct frame.
